calc_ctrl_fsm: RTL and testbench
================================

Name: calc_ctrl_fsm

Overview:
Sequencing controller that sits directly upstream of the ALU. It collects operand A, operand B and an operator from the user-input path, and drives the ALU's A/B buses and one-hot enables. It then captures the selected ALU result (or the divide-by-zero error) into a held output register for the display stage. It owns every ALU transaction; the ALU stays purely combinational.

Parameters:
WIDTH, 8, operand width; the result register is 2*WIDTH bits.
ALU_LATENCY, 1, number of cycles the enables are held before the result is captured (range 1..15).

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  reset, asynchronous, active-low
data_in  input  WIDTH  operand value from the input path
load  input  1  one-cycle pulse: latch data_in as the next operand
op_sel  input  2  operator code: 00 add, 01 sub, 10 mul, 11 div
start  input  1  one-cycle pulse: latch op_sel and execute
clear  input  1  synchronous abort; returns to IDLE
A  output  WIDTH  ALU operand A (registered)
B  output  WIDTH  ALU operand B (registered)
enable_add / enable_sub / enable_mul / enable_div  output  1 each  ALU one-hot enables
result_add  input  WIDTH+1  ALU sum
result_sub  input  WIDTH  ALU difference
result_mul  input  2*WIDTH  ALU product
result_div  input  WIDTH  ALU quotient
error  input  1  ALU divide-by-zero flag
result  output  2*WIDTH  captured result, zero-extended
result_valid  output  1  high while result holds a valid answer
err_flag  output  1  high while in ERR
busy  output  1  high in EXEC
state  output  3  current state encoding, for debug and display

Behaviour:
- Reset (rst_n low, async): state=IDLE. A, B, result, the op register and the latency counter all go to 0. All enables, result_valid, err_flag and busy go to 0.
- States and encodings: IDLE=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DONE=4, ERR=5. Encodings 6 and 7 are illegal and return to IDLE on the next edge.
- IDLE: on load, A<=data_in and go to WAIT_B. start is ignored.
- WAIT_B: on load, B<=data_in and go to WAIT_OP. start is ignored.
- WAIT_OP: on start, latch op_sel, load the counter with ALU_LATENCY-1 and go to EXEC. load is ignored.
- EXEC:
  - Exactly one enable is high, decoded from the latched op; busy=1.
  - The counter decrements each cycle.
  - On the edge where the counter equals 0, capture the result and leave EXEC. Enables are therefore high for exactly ALU_LATENCY cycles.
- Capture:
  - add: result = zero-extended result_add (9 bits).
  - sub: result = zero-extended result_sub (8-bit wrap, e.g. 123-215 = 164).
  - mul: result = result_mul.
  - div: if error=1, go to ERR with result=0; otherwise result = zero-extended result_div.
  - error is sampled only when the op is div.
- DONE: result_valid=1, and result is held.
  - load: A<=data_in, result_valid<=0, go to WAIT_B (new calculation).
  - start: chained operation. A<=result[WIDTH-1:0], the operator is re-latched from op_sel, and the FSM goes to EXEC reusing B.
- ERR: err_flag=1 and result=0. Only clear or reset exits ERR.
- clear: highest synchronous priority in every state, including mid-EXEC.
  - Next state is IDLE; enables drop on the same edge.
  - A, B, result, result_valid and err_flag go to 0.
- Outside EXEC all enables are 0.
- load and start in the same cycle: only the input relevant to the current state acts (as listed above).
- Async reset mid-EXEC: everything returns to reset values immediately and no capture occurs.

Decomposition:
- Package calc_pkg holds:
  - the state encoding constants;
  - op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - the default WIDTH.
- One natural sub-module, calc_result_mux: a combinational block that selects the ALU result by op and zero-extends it to 2*WIDTH. The FSM, counter and registers stay in calc_ctrl_fsm.

Test Plan:
1. load 15, load 10, op 00, start -> enable_add high for 1 cycle, then DONE with result=25 and result_valid=1.
2. 100, 27, op 01 -> result=73. Then 123, 215, op 01 -> result=164.
3. 200, 55, op 10 -> result=11000. Then start with op 00 in DONE -> A=0xF8, B=55, result=303.
4. 123, 0, op 11 with the ALU asserting error -> ERR, err_flag=1, result=0. load is ignored; clear -> IDLE with all outputs 0.
5. ALU_LATENCY=3, 100/27 -> enable_div high for exactly 3 cycles, then result=3. Both clear mid-EXEC and rst_n low mid-EXEC -> IDLE, enables 0 and result unchanged at 0.
6. load and start pulsed together in IDLE -> only A latched and state=WAIT_B. A forced illegal state 7 -> IDLE on the next edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  // One-hot ALU enables ordered {add, sub, mul, div}.
  function automatic logic [3:0] op_onehot(input op_t op);
    logic [3:0] en;
    en = '0;
    case (op)
      OP_ADD: en = 4'b1000;
      OP_SUB: en = 4'b0100;
      OP_MUL: en = 4'b0010;
      OP_DIV: en = 4'b0001;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/calc_ctrl_fsm_if.sv
// User-input, ALU and display-side signals of the calculator controller.
interface calc_ctrl_fsm_if #(
  parameter int WIDTH = calc_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0]   data_in;
  logic               load;
  logic [1:0]         op_sel;
  logic               start;
  logic               clear;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               enable_add;
  logic               enable_sub;
  logic               enable_mul;
  logic               enable_div;
  logic [WIDTH:0]     result_add;
  logic [WIDTH-1:0]   result_sub;
  logic [2*WIDTH-1:0] result_mul;
  logic [WIDTH-1:0]   result_div;
  logic               error;
  logic [2*WIDTH-1:0] result;
  logic               result_valid;
  logic               err_flag;
  logic               busy;
  logic [2:0]         state;

  modport master (
    input  data_in, load, op_sel, start, clear,
    input  result_add, result_sub, result_mul, result_div, error,
    output A, B, enable_add, enable_sub, enable_mul, enable_div,
    output result, result_valid, err_flag, busy, state
  );

  modport slave (
    output data_in, load, op_sel, start, clear,
    output result_add, result_sub, result_mul, result_div, error,
    input  A, B, enable_add, enable_sub, enable_mul, enable_div,
    input  result, result_valid, err_flag, busy, state
  );
endinterface

// File: rtl/calc_result_mux.sv
// Selects the ALU result for the latched operator, zero-extended to 2*WIDTH.
module calc_result_mux
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_t                i_op,
  input  logic [WIDTH:0]     i_add,
  input  logic [WIDTH-1:0]   i_sub,
  input  logic [2*WIDTH-1:0] i_mul,
  input  logic [WIDTH-1:0]   i_div,
  output logic [2*WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD: o_result = (2*WIDTH)'(i_add);
      OP_SUB: o_result = (2*WIDTH)'(i_sub);
      OP_MUL: o_result = i_mul;
      OP_DIV: o_result = (2*WIDTH)'(i_div);
    endcase
  end

endmodule

// File: rtl/calc_ctrl_fsm.sv
// Operand/operator sequencer driving a combinational ALU and holding its
// captured result for the display stage.
module calc_ctrl_fsm
  import calc_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int ALU_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  calc_ctrl_fsm_if.master bus
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t             r_state;
  op_t                r_op;
  logic [3:0]         r_cnt;
  logic [3:0]         r_en;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_result;
  logic               r_valid;
  logic               r_err;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_result;
  logic               w_div_err;
  op_t                w_op_sel;

  assign w_op_sel  = op_t'(bus.op_sel);
  assign w_div_err = (r_op == OP_DIV) && bus.error;

  calc_result_mux #(.WIDTH(WIDTH)) u_mux (
    .i_op     (r_op),
    .i_add    (bus.result_add),
    .i_sub    (bus.result_sub),
    .i_mul    (bus.result_mul),
    .i_div    (bus.result_div),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_en     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (bus.clear) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_en     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            r_a     <= bus.data_in;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (bus.load) begin
            r_b     <= bus.data_in;
            r_state <= ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          if (bus.start) begin
            r_op    <= w_op_sel;
            r_cnt   <= LAT_M1;
            r_en    <= op_onehot(w_op_sel);
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_en   <= '0;
            r_busy <= 1'b0;
            if (w_div_err) begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= ST_ERR;
            end else begin
              r_result <= w_result;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          // A new load takes priority over chaining when both arrive together.
          if (bus.load) begin
            r_a     <= bus.data_in;
            r_valid <= 1'b0;
            r_state <= ST_WAIT_B;
          end else if (bus.start) begin
            r_a     <= r_result[WIDTH-1:0];
            r_op    <= w_op_sel;
            r_cnt   <= LAT_M1;
            r_en    <= op_onehot(w_op_sel);
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_state <= ST_EXEC;
          end
        end
        ST_ERR: begin
          r_result <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A            = r_a;
  assign bus.B            = r_b;
  assign bus.enable_add   = r_en[3];
  assign bus.enable_sub   = r_en[2];
  assign bus.enable_mul   = r_en[1];
  assign bus.enable_div   = r_en[0];
  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;
  assign bus.err_flag     = r_err;
  assign bus.busy         = r_busy;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Directed bench for calc_ctrl_fsm: latency-1 and latency-3 instances share stimulus.
module tb_calc_ctrl_fsm;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       load = 1'b0;
  logic [1:0] op_sel = '0;
  logic       start = 1'b0;
  logic       clear = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calc_ctrl_fsm_if #(.WIDTH(8)) bus1 ();
  calc_ctrl_fsm_if #(.WIDTH(8)) bus3 ();

  calc_ctrl_fsm #(.WIDTH(8), .ALU_LATENCY(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  calc_ctrl_fsm #(.WIDTH(8), .ALU_LATENCY(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  assign bus1.data_in = data_in;
  assign bus1.load    = load;
  assign bus1.op_sel  = op_sel;
  assign bus1.start   = start;
  assign bus1.clear   = clear;
  assign bus3.data_in = data_in;
  assign bus3.load    = load;
  assign bus3.op_sel  = op_sel;
  assign bus3.start   = start;
  assign bus3.clear   = clear;

  // Combinational ALU models; divide by zero raises error.
  assign bus1.result_add = {1'b0, bus1.A} + {1'b0, bus1.B};
  assign bus1.result_sub = bus1.A - bus1.B;
  assign bus1.result_mul = 16'(bus1.A) * 16'(bus1.B);
  assign bus1.result_div = (bus1.B == 8'd0) ? 8'd0 : bus1.A / bus1.B;
  assign bus1.error      = (bus1.B == 8'd0);
  assign bus3.result_add = {1'b0, bus3.A} + {1'b0, bus3.B};
  assign bus3.result_sub = bus3.A - bus3.B;
  assign bus3.result_mul = 16'(bus3.A) * 16'(bus3.B);
  assign bus3.result_div = (bus3.B == 8'd0) ? 8'd0 : bus3.A / bus3.B;
  assign bus3.error      = (bus3.B == 8'd0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    data_in = v;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] op);
    op_sel = op;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_exec1();
    int g;
    g = 0;
    while (bus1.state == 3'd3 && g < 20) begin
      tick();
      g++;
    end
    check("exec_ends", 32'(g < 20), 32'd1);
  endtask

  task automatic run_calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    do_load(a);
    do_load(b);
    do_start(op);
    wait_exec1();
  endtask

  function automatic logic [3:0] en_vec1();
    return {bus1.enable_add, bus1.enable_sub, bus1.enable_mul, bus1.enable_div};
  endfunction

  function automatic logic [3:0] en_vec3();
    return {bus3.enable_add, bus3.enable_sub, bus3.enable_mul, bus3.enable_div};
  endfunction

  initial begin
    int n_en;
    repeat (3) tick();
    check("rst_state", 32'(bus1.state), 32'd0);
    check("rst_A", 32'(bus1.A), 32'd0);
    check("rst_B", 32'(bus1.B), 32'd0);
    check("rst_result", 32'(bus1.result), 32'd0);
    check("rst_flags", {28'd0, bus1.result_valid, bus1.err_flag, bus1.busy, 1'b0}, 32'd0);
    check("rst_en", 32'(en_vec1()), 32'd0);
    rst_n = 1'b1;
    tick();

    // Add
    do_load(8'd15);
    check("t1_state_wb", 32'(bus1.state), 32'd1);
    check("t1_A", 32'(bus1.A), 32'd15);
    do_load(8'd10);
    check("t1_state_wop", 32'(bus1.state), 32'd2);
    check("t1_B", 32'(bus1.B), 32'd10);
    do_start(2'b00);
    check("t1_state_exec", 32'(bus1.state), 32'd3);
    check("t1_en", 32'(en_vec1()), 32'b1000);
    check("t1_busy", 32'(bus1.busy), 32'd1);
    tick();
    check("t1_state_done", 32'(bus1.state), 32'd4);
    check("t1_en_off", 32'(en_vec1()), 32'd0);
    check("t1_result", 32'(bus1.result), 32'd25);
    check("t1_valid", 32'(bus1.result_valid), 32'd1);

    // Subtract, including wrap
    do_load(8'd100);
    check("t2_valid_drop", 32'(bus1.result_valid), 32'd0);
    check("t2_state", 32'(bus1.state), 32'd1);
    do_load(8'd27);
    do_start(2'b01);
    check("t2_en", 32'(en_vec1()), 32'b0100);
    wait_exec1();
    check("t2_result", 32'(bus1.result), 32'd73);
    run_calc(8'd123, 8'd215, 2'b01);
    check("t2_wrap", 32'(bus1.result), 32'd164);

    // Multiply, then chained add
    run_calc(8'd200, 8'd55, 2'b10);
    check("t3_mul", 32'(bus1.result), 32'd11000);
    check("t3_state", 32'(bus1.state), 32'd4);
    do_start(2'b00);
    check("t3_chain_A", 32'(bus1.A), 32'hF8);
    check("t3_chain_B", 32'(bus1.B), 32'd55);
    check("t3_chain_en", 32'(en_vec1()), 32'b1000);
    tick();
    check("t3_chain_result", 32'(bus1.result), 32'd303);
    check("t3_chain_state", 32'(bus1.state), 32'd4);

    // Divide by zero
    run_calc(8'd123, 8'd0, 2'b11);
    check("t4_state", 32'(bus1.state), 32'd5);
    check("t4_err", 32'(bus1.err_flag), 32'd1);
    check("t4_result", 32'(bus1.result), 32'd0);
    check("t4_valid", 32'(bus1.result_valid), 32'd0);
    do_load(8'd7);
    check("t4_load_ign_state", 32'(bus1.state), 32'd5);
    check("t4_load_ign_A", 32'(bus1.A), 32'd123);
    do_clear();
    check("t4_clr_state", 32'(bus1.state), 32'd0);
    check("t4_clr_A", 32'(bus1.A), 32'd0);
    check("t4_clr_B", 32'(bus1.B), 32'd0);
    check("t4_clr_err", 32'(bus1.err_flag), 32'd0);
    check("t4_clr_result", 32'(bus1.result), 32'd0);

    // load+start together in IDLE, then illegal state recovery
    data_in = 8'd42;
    op_sel  = 2'b10;
    load    = 1'b1;
    start   = 1'b1;
    tick();
    load    = 1'b0;
    start   = 1'b0;
    check("t6_state", 32'(bus1.state), 32'd1);
    check("t6_A", 32'(bus1.A), 32'd42);
    check("t6_busy", 32'(bus1.busy), 32'd0);
    force u_dut.r_state = state_t'(3'd7);
    #1;
    check("t6_forced", 32'(bus1.state), 32'd7);
    release u_dut.r_state;
    tick();
    check("t6_illegal_recover", 32'(bus1.state), 32'd0);

    // Latency 3 instance
    do_clear();
    do_load(8'd100);
    do_load(8'd27);
    do_start(2'b11);
    check("t5_en", 32'(en_vec3()), 32'b0001);
    n_en = 0;
    while (bus3.enable_div && n_en < 10) begin
      n_en++;
      tick();
    end
    check("t5_en_cycles", 32'(n_en), 32'd3);
    check("t5_result", 32'(bus3.result), 32'd3);
    check("t5_state", 32'(bus3.state), 32'd4);
    do_clear();
    do_load(8'd100);
    do_load(8'd27);
    do_start(2'b00);
    tick();
    check("t5_mid_exec", 32'(bus3.state), 32'd3);
    do_clear();
    check("t5_clr_state", 32'(bus3.state), 32'd0);
    check("t5_clr_en", 32'(en_vec3()), 32'd0);
    check("t5_clr_result", 32'(bus3.result), 32'd0);
    do_load(8'd100);
    do_load(8'd27);
    do_start(2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", 32'(bus3.state), 32'd0);
    check("t5_rst_en", 32'(en_vec3()), 32'd0);
    check("t5_rst_result", 32'(bus3.result), 32'd0);
    check("t5_rst_A", 32'(bus3.A), 32'd0);
    tick();
    check("t5_rst_hold", 32'(bus3.result), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
